// File: rtl/uno_pkg.sv
// Shared card types, deck constants and the index-to-card mapping
// used by the UNO referee and its deck.
package uno_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        BLUE   = 2'b11
    } color_e;

    typedef struct packed {
        color_e     color;
        logic [3:0] value;
    } card_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAL,
        ST_TURN,
        ST_WAIT,
        ST_DRAW
    } state_e;

    localparam logic [3:0] SKIP      = 4'd10;
    localparam logic [3:0] REVERSE   = 4'd11;
    localparam logic [3:0] DRAW_TWO  = 4'd12;
    localparam logic [3:0] WILD      = 4'd13;
    localparam logic [3:0] WILD_FOUR = 4'd14;

    localparam card_t      NONE_CARD = 6'h3F;
    localparam logic [6:0] DECK_SIZE = 7'd108;

    // Indices at or above DECK_SIZE map to NONE_CARD.
    function automatic card_t idx_to_card(input logic [6:0] idx);
        card_t      c;
        logic [6:0] off;
        c   = NONE_CARD;
        off = 7'd0;
        if (idx < 7'd4) begin
            c.color = color_e'(idx[1:0]);
            c.value = 4'd0;
        end else if (idx < 7'd100) begin
            off     = idx - 7'd4;
            c.color = color_e'(off[2:1]);
            c.value = off[6:3] + 4'd1;
        end else if (idx < 7'd104) begin
            off     = idx - 7'd100;
            c.color = color_e'(off[1:0]);
            c.value = WILD;
        end else if (idx < DECK_SIZE) begin
            off     = idx - 7'd104;
            c.color = color_e'(off[1:0]);
            c.value = WILD_FOUR;
        end
        return c;
    endfunction

endpackage

// File: rtl/uno_deck.sv
// Pseudo-random deck: 7-bit LFSR, index mapping, remaining counter.
// The LFSR only advances on step and is never reseeded by clear.
module uno_deck
    import uno_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  step,
    output logic  valid,
    output card_t card,
    output logic  empty
);

    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] remaining_q, remaining_d;
    logic [6:0] lfsr_nxt;
    logic [6:0] idx;
    logic       adv;

    assign empty    = (remaining_q == 7'd0);
    assign lfsr_nxt = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign idx      = lfsr_nxt - 7'd1;
    assign adv      = step && !empty;

    always_comb begin
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        valid       = 1'b0;
        card        = idx_to_card(idx);
        if (adv) begin
            lfsr_d = lfsr_nxt;
            valid  = (idx < DECK_SIZE);
        end
        if (clear) begin
            remaining_d = DECK_SIZE;
        end else if (valid) begin
            remaining_d = remaining_q - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q      <= 7'h01;
            remaining_q <= DECK_SIZE;
        end else begin
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: rtl/uno_referee.sv
// UNO table referee: deals, judges plays, serves draws.
// Optional ILLEGAL_CNT_EN adds a saturating reject counter output.
module uno_referee
    import uno_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       out_valid,
    input  logic [5:0] out_cards,
    input  logic       draw_card,
    output logic       start,
    output logic [5:0] prev_card,
    output logic       skip,
    output logic       draw_two,
    output logic       draw_four,
    output logic [5:0] drawed_card,
    output logic       draw_valid,
    output logic       accept,
    output logic       reject,
    output logic       deck_empty
`ifdef ILLEGAL_CNT_EN
    ,
    output logic [7:0] illegal_cnt
`endif
);

    state_e state_q, state_d;
    card_t  prev_q, prev_d;
    card_t  drawed_q, drawed_d;
    logic   skip_q, skip_d;
    logic   two_q, two_d;
    logic   four_q, four_d;
    logic   dv_q, dv_d;
    logic   acc_q, acc_d;
    logic   rej_q, rej_d;
    logic   empty_q, empty_d;

    logic   deck_clear;
    logic   deck_step;
    logic   deck_valid;
    card_t  deck_card;
    logic   deck_out;
    card_t  play;
    logic   legal;

    uno_deck u_deck (
        .clk   (clk),
        .reset (reset),
        .clear (deck_clear),
        .step  (deck_step),
        .valid (deck_valid),
        .card  (deck_card),
        .empty (deck_out)
    );

    assign play  = card_t'(out_cards);
    assign legal = (play.color == prev_q.color)
                || (play.value == prev_q.value)
                || (play.value == WILD)
                || (play.value == WILD_FOUR)
                || (prev_q == NONE_CARD);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        drawed_d   = drawed_q;
        skip_d     = skip_q;
        two_d      = two_q;
        four_d     = four_q;
        empty_d    = empty_q;
        dv_d       = 1'b0;
        acc_d      = 1'b0;
        rej_d      = 1'b0;
        deck_clear = 1'b0;
        deck_step  = 1'b0;
        if (new_game) begin
            deck_clear = 1'b1;
            prev_d     = NONE_CARD;
            skip_d     = 1'b0;
            two_d      = 1'b0;
            four_d     = 1'b0;
            empty_d    = 1'b0;
            state_d    = ST_DEAL;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DEAL: begin
                    // Wilds are burned; an exhausted deck leaves NONE on top.
                    deck_step = 1'b1;
                    if (deck_out) begin
                        state_d = ST_TURN;
                    end else if (deck_valid && deck_card.value < WILD) begin
                        prev_d  = deck_card;
                        state_d = ST_TURN;
                    end
                end
                ST_TURN: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (out_valid) begin
                        if (legal) begin
                            prev_d  = play;
                            acc_d   = 1'b1;
                            skip_d  = (play.value == SKIP)
                                   || (play.value == REVERSE);
                            two_d   = (play.value == DRAW_TWO);
                            four_d  = (play.value == WILD_FOUR);
                            state_d = ST_TURN;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end else if (draw_card) begin
                        state_d = ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (deck_out) begin
                        drawed_d = NONE_CARD;
                        empty_d  = 1'b1;
                        dv_d     = 1'b1;
                        skip_d   = 1'b0;
                        two_d    = 1'b0;
                        four_d   = 1'b0;
                        state_d  = ST_TURN;
                    end else begin
                        deck_step = 1'b1;
                        if (deck_valid) begin
                            drawed_d = deck_card;
                            dv_d     = 1'b1;
                            skip_d   = 1'b0;
                            two_d    = 1'b0;
                            four_d   = 1'b0;
                            state_d  = ST_TURN;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= NONE_CARD;
            drawed_q <= NONE_CARD;
            skip_q   <= 1'b0;
            two_q    <= 1'b0;
            four_q   <= 1'b0;
            dv_q     <= 1'b0;
            acc_q    <= 1'b0;
            rej_q    <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            drawed_q <= drawed_d;
            skip_q   <= skip_d;
            two_q    <= two_d;
            four_q   <= four_d;
            dv_q     <= dv_d;
            acc_q    <= acc_d;
            rej_q    <= rej_d;
            empty_q  <= empty_d;
        end
    end

    assign start       = (state_q == ST_TURN);
    assign prev_card   = prev_q;
    assign drawed_card = drawed_q;
    assign skip        = skip_q;
    assign draw_two    = two_q;
    assign draw_four   = four_q;
    assign draw_valid  = dv_q;
    assign accept      = acc_q;
    assign reject      = rej_q;
    assign deck_empty  = empty_q;

`ifdef ILLEGAL_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (new_game) begin
            cnt_d = 8'd0;
        end else if (rej_d && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_uno_referee.sv
// Directed bench for uno_referee; define ILLEGAL_CNT_EN to
// also exercise the reject counter.
module tb_uno_referee;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_game;
    logic       out_valid;
    logic [5:0] out_cards;
    logic       draw_card;
    logic       start;
    logic [5:0] prev_card;
    logic       skip;
    logic       draw_two;
    logic       draw_four;
    logic [5:0] drawed_card;
    logic       draw_valid;
    logic       accept;
    logic       reject;
    logic       deck_empty;
`ifdef ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    uno_referee dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .out_valid   (out_valid),
        .out_cards   (out_cards),
        .draw_card   (draw_card),
        .start       (start),
        .prev_card   (prev_card),
        .skip        (skip),
        .draw_two    (draw_two),
        .draw_four   (draw_four),
        .drawed_card (drawed_card),
        .draw_valid  (draw_valid),
        .accept      (accept),
        .reject      (reject),
        .deck_empty  (deck_empty)
`ifdef ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic game();
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
        for (int i = 0; i < 40 && !start; i++) cyc();
    endtask

    task automatic play(input logic [5:0] c, input logic with_draw);
        out_valid = 1'b1;
        out_cards = c;
        draw_card = with_draw;
        cyc();
        out_valid = 1'b0;
        draw_card = 1'b0;
    endtask

    task automatic do_draw(output logic [5:0] c, output logic ok,
                           output logic st);
        ok = 1'b0;
        st = 1'b0;
        c  = 6'h00;
        draw_card = 1'b1;
        cyc();
        draw_card = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (draw_valid) begin
                ok = 1'b1;
                st = start;
                c  = drawed_card;
                break;
            end
        end
        cyc();
    endtask

    logic [5:0] c;
    logic       ok;
    logic       st;
    int         tmo;

    initial begin
        reset     = 1'b1;
        new_game  = 1'b0;
        out_valid = 1'b0;
        out_cards = 6'h00;
        draw_card = 1'b0;
        #12;
        chk("rst_prev", {2'b0, prev_card}, 8'h3F);
        chk("rst_drawed", {2'b0, drawed_card}, 8'h3F);
        chk("rst_lfsr", {1'b0, dut.u_deck.lfsr_q}, 8'h01);
        chk("rst_remaining", {1'b0, dut.u_deck.remaining_q}, 8'd108);
        chk("rst_bits", {start, skip, draw_two, draw_four,
                         draw_valid, accept, reject, deck_empty}, 8'h00);
        reset = 1'b0;
        cyc();
        chk("idle_start", {7'b0, start}, 8'h00);

        game();
        chk("deal_start", {7'b0, start}, 8'h01);
        chk("deal_prev", {2'b0, prev_card}, 8'h10);
        chk("deal_lfsr", {1'b0, dut.u_deck.lfsr_q}, 8'h02);
        cyc();
        chk("start_one_cycle", {7'b0, start}, 8'h00);

        do_draw(c, ok, st);
        chk("draw1_ok", {7'b0, ok}, 8'h01);
        chk("draw1_card", {2'b0, c}, 8'h30);
        chk("draw1_start", {7'b0, st}, 8'h01);
        chk("draw1_lfsr", {1'b0, dut.u_deck.lfsr_q}, 8'h04);
        chk("draw1_remaining", {1'b0, dut.u_deck.remaining_q}, 8'd106);

        play(6'h25, 1'b0);
        chk("ill_reject", {6'b0, reject, accept}, 8'h02);
        chk("ill_prev", {2'b0, prev_card}, 8'h10);
        cyc();
        chk("reject_pulse", {7'b0, reject}, 8'h00);

        play(6'h3E, 1'b0);
        chk("w4_accept", {6'b0, reject, accept}, 8'h01);
        chk("w4_flags", {5'b0, skip, draw_two, draw_four}, 8'h01);
        chk("w4_prev", {2'b0, prev_card}, 8'h3E);
        cyc();

        play(6'h3A, 1'b0);
        chk("skip_flags", {5'b0, skip, draw_two, draw_four}, 8'h04);
        cyc();
        play(6'h1A, 1'b0);
        chk("valmatch_acc", {7'b0, accept}, 8'h01);
        cyc();

        play(6'h13, 1'b1);
        chk("both_accept", {7'b0, accept}, 8'h01);
        chk("both_skip", {7'b0, skip}, 8'h00);
        chk("both_dv0", {7'b0, draw_valid}, 8'h00);
        cyc();
        cyc();
        chk("both_dv1", {7'b0, draw_valid}, 8'h00);
        chk("both_prev", {2'b0, prev_card}, 8'h13);

        play(6'h1C, 1'b0);
        chk("d2_flags", {5'b0, skip, draw_two, draw_four}, 8'h02);
        cyc();
        play(6'h25, 1'b0);
        chk("d2_keep_flags", {5'b0, skip, draw_two, draw_four}, 8'h02);
        chk("d2_keep_prev", {2'b0, prev_card}, 8'h1C);
        cyc();

        do_draw(c, ok, st);
        chk("draw2_card", {2'b0, c}, 8'h11);
        chk("draw2_flags", {5'b0, skip, draw_two, draw_four}, 8'h00);
        chk("draw2_hold", {2'b0, drawed_card}, 8'h11);

        game();
        chk("regame_prev", {2'b0, prev_card}, 8'h12);
        chk("regame_lfsr", {1'b0, dut.u_deck.lfsr_q}, 8'h10);
        chk("regame_rem", {1'b0, dut.u_deck.remaining_q}, 8'd107);
        cyc();

`ifdef ILLEGAL_CNT_EN
        chk("cnt_cleared", illegal_cnt, 8'd0);
        out_valid = 1'b1;
        out_cards = 6'h25;
        repeat (3) cyc();
        chk("cnt_3", illegal_cnt, 8'd3);
        repeat (297) cyc();
        out_valid = 1'b0;
        cyc();
        chk("cnt_sat", illegal_cnt, 8'd255);
        chk("cnt_prev", {2'b0, prev_card}, 8'h12);
`endif

        tmo = 0;
        for (int n = 0; n < 109; n++) begin
            do_draw(c, ok, st);
            if (!ok) tmo++;
        end
        chk("deck_timeouts", tmo[7:0], 8'd0);
        chk("empty_card", {2'b0, c}, 8'h3F);
        chk("empty_flag", {7'b0, deck_empty}, 8'h01);
        chk("empty_rem", {1'b0, dut.u_deck.remaining_q}, 8'd0);

        game();
        chk("empty_cleared", {7'b0, deck_empty}, 8'h00);
        chk("empty_regame_rem", {1'b0, dut.u_deck.remaining_q}, 8'd107);
        cyc();

        draw_card = 1'b1;
        cyc();
        draw_card = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_lfsr", {1'b0, dut.u_deck.lfsr_q}, 8'h01);
        chk("abort_prev", {2'b0, prev_card}, 8'h3F);
        #3;
        reset = 1'b0;
        cyc();
        cyc();
        chk("abort_bits", {start, draw_valid, accept, deck_empty},
            8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uno_referee.md
UNO_REFEREE -- requirements
Module: uno_referee

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: new_game  in  1  one-cycle pulse that restarts deck and table; out_valid  in  1  player presents a card; out_cards  in  6  played card {color[1:0], value[3:0]}; draw_card  in  1  player requests a draw.
REQ-003 SHALL have ports: start  out  1  turn-begin pulse; prev_card  out  6  top of discard pile; skip, draw_two, draw_four  out  1 each  penalty flags for current turn; drawed_card  out  6  dealt card; draw_valid  out  1  dealt-card strobe; accept, reject  out  1 each  play verdict strobes; deck_empty  out  1  deck exhausted.
REQ-004 Card encoding SHALL be: color 00 red, 01 yellow, 10 green, 11 blue; value 0-9, 10 skip, 11 reverse, 12 draw two, 13 wild, 14 wild draw four; 6'h3F = NONE.

Function
REQ-005 Deck SHALL be a 7-bit Fibonacci LFSR, polynomial x^7+x^6+1, next = {q[5:0], q[6]^q[5]}; each step advances once per clock; index = lfsr-1.
REQ-006 Index mapping SHALL be: 0-3 value 0, color=idx; 4-99 value 1+((idx-4)>>3), color ((idx-4)>>1)&3; 100-103 value 13, color idx-100; 104-107 value 14, color idx-104; index >=108 SHALL be skipped (costs one cycle, no card).
REQ-007 A 7-bit remaining counter SHALL start at 108 and decrement per card dealt, never wrapping below 0.
REQ-008 FSM states SHALL be IDLE, DEAL, TURN, WAIT, DRAW.
REQ-009 IDLE -> DEAL on new_game; DEAL SHALL step until a card with value <13 is dealt, load it into prev_card, go TURN; wild cards dealt here are consumed.
REQ-010 TURN SHALL assert start for exactly one cycle, then go WAIT.
REQ-011 In WAIT, out_valid legal (color match, value match, value 13/14, or prev_card NONE) SHALL: load prev_card, pulse accept one cycle, set skip (value 10 or 11), draw_two (12), draw_four (14), clear others, go TURN.
REQ-012 Illegal out_valid SHALL pulse reject one cycle, leave prev_card and flags unchanged, remain in WAIT.
REQ-013 out_valid and draw_card together SHALL be treated as play only; draw_card ignored that cycle.
REQ-014 draw_card in WAIT -> DRAW; DRAW SHALL step until a valid index, then set drawed_card, pulse draw_valid one cycle, clear penalty flags, go TURN; latency 1 to 20 cycles.
REQ-015 DRAW with remaining==0 SHALL within one cycle set deck_empty=1, drawed_card=NONE, pulse draw_valid, go TURN.
REQ-016 new_game in any state SHALL reset remaining to 108, clear deck_empty, flags, prev_card to NONE, go DEAL; LFSR SHALL NOT be reseeded.
REQ-017 drawed_card and prev_card SHALL hold value between updates.

Reset
REQ-018 On reset: state IDLE, lfsr 7'h01, remaining 108, prev_card and drawed_card 6'h3F, all 1-bit outputs 0.
REQ-019 Reset mid-DRAW or mid-DEAL SHALL abort with no draw_valid pulse.

Configuration
REQ-020 With ILLEGAL_CNT_EN defined, SHALL add output illegal_cnt[7:0], incremented per reject, saturating at 255, cleared by reset or new_game; without it, port and logic absent.

Structure
REQ-021 Package uno_pkg SHALL hold card typedef, color enum, value constants (SKIP, REVERSE, DRAW_TWO, WILD, WILD_FOUR), NONE_CARD, DECK_SIZE=108.
REQ-022 Sub-module uno_deck SHALL hold LFSR, index mapping and remaining counter with step/valid/card/empty ports.

Verification
REQ-023 reset, new_game -> lfsr 2, prev_card 6'h10 (yellow 0), one start pulse.
REQ-024 then draw_card -> lfsr 4, draw_valid with drawed_card 6'h30 (blue 0), start pulse, remaining 106.
REQ-025 prev_card 6'h10, out_cards 6'h25 (green 5) -> reject, prev_card unchanged; out_cards 6'h3E -> accept, draw_four=1.
REQ-026 out_valid and draw_card same cycle with legal 6'h13 -> accept, no draw_valid, skip=0.
REQ-027 108 draws then one more -> draw_valid, drawed_card 6'h3F, deck_empty=1; new_game clears deck_empty.
REQ-028 ILLEGAL_CNT_EN: 300 illegal plays -> illegal_cnt 255.
